// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder-sharing arbiter: FSM state encoding and
// default sizing (NREQ requesters, W-bit operands, IDW-bit requester id).
package adder_arb_pkg;
  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;
  localparam int IDW_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;
endpackage

// File: rtl/adder_share_arbiter_if.sv
// Bundle of every non-clock signal of adder_share_arbiter.
//   requester side : req, a_in, b_in, c_in (in) / gnt (out)
//   shared Adder   : add_a, add_b, add_ci (out) / add_s, add_co (in)
//   result channel : res_valid, res_id, res_sum, res_cout (out) / res_ready (in)
//   status         : busy (out)
// slave  = the arbiter's view, master = the surrounding subsystem's view.
interface adder_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   c_in;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic              add_ci;
  logic [W-1:0]      add_s;
  logic              add_co;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic [W-1:0]      res_sum;
  logic              res_cout;
  logic              busy;

  modport slave (
    input  req, a_in, b_in, c_in, add_s, add_co, res_ready,
    output gnt, add_a, add_b, add_ci, res_valid, res_id, res_sum, res_cout, busy
  );

  modport master (
    output req, a_in, b_in, c_in, add_s, add_co, res_ready,
    input  gnt, add_a, add_b, add_ci, res_valid, res_id, res_sum, res_cout, busy
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   i_req    : request vector
//   i_ptr    : highest-priority index for this pick
//   o_any    : at least one request set
//   o_win_id : first set request scanning i_ptr, i_ptr+1, ... mod NREQ
//   o_win    : one-hot of o_win_id (all zero when !o_any)
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic            o_any,
  output logic [IDW-1:0]  o_win_id,
  output logic [NREQ-1:0] o_win
);
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;

  // Scan from the farthest offset down so the nearest hit to i_ptr is the
  // last one written and therefore wins.
  always_comb begin
    o_any    = 1'b0;
    o_win_id = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NREQ)) w_sum = w_sum - (IDW+1)'(NREQ);
      w_idx = w_sum[IDW-1:0];
      if (i_req[w_idx]) begin
        o_any    = 1'b1;
        o_win_id = w_idx;
      end
    end
  end

  always_comb begin
    o_win = '0;
    if (o_any) o_win[o_win_id] = 1'b1;
  end
endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one external W-bit Adder among NREQ requesters.
// One transaction: IDLE (pick winner, register its operands onto the Adder,
// pulse gnt) -> ISSUE (Adder settles, capture sum/carry) -> HOLD (present
// result until res_ready) -> IDLE with the pointer moved past the winner.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : all handshake / operand / result signals (slave view)
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_share_arbiter_if.slave bus
);
  arb_state_e r_state, w_next;

  logic [IDW-1:0]         r_ptr;
  logic [IDW-1:0]         r_win_id;
  logic [NREQ-1:0]        r_gnt;
  logic [W-1:0]           r_add_a, r_add_b;
  logic                   r_add_ci;
  logic                   r_res_valid;
  logic [IDW-1:0]         r_res_id;
  logic [W-1:0]           r_res_sum;
  logic                   r_res_cout;

  logic                   w_any;
  logic [IDW-1:0]         w_win_id;
  logic [NREQ-1:0]        w_win;
  logic [NREQ-1:0][W-1:0] w_a, w_b;
  logic [IDW-1:0]         w_ptr_nxt;

  assign w_a = bus.a_in;
  assign w_b = bus.b_in;

  assign w_ptr_nxt = (r_win_id == IDW'(NREQ-1)) ? '0 : r_win_id + IDW'(1);

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_any   (w_any),
    .o_win_id(w_win_id),
    .o_win   (w_win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   w_next = HOLD;
      HOLD:    if (bus.res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_win_id    <= '0;
      r_gnt       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_ci    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_sum   <= '0;
      r_res_cout  <= 1'b0;
    end else begin
      r_gnt <= '0;  // gnt is a single-cycle pulse
      unique case (r_state)
        IDLE: if (w_any) begin
          r_gnt    <= w_win;
          r_win_id <= w_win_id;
          r_add_a  <= w_a[w_win_id];
          r_add_b  <= w_b[w_win_id];
          r_add_ci <= bus.c_in[w_win_id];
        end
        ISSUE: begin
          r_res_sum   <= bus.add_s;
          r_res_cout  <= bus.add_co;
          r_res_id    <= r_win_id;
          r_res_valid <= 1'b1;
        end
        HOLD: if (bus.res_ready) begin
          r_res_valid <= 1'b0;
          r_ptr       <= w_ptr_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.add_ci    = r_add_ci;
  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.res_sum   = r_res_sum;
  assign bus.res_cout  = r_res_cout;
  assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;
  import adder_arb_pkg::*;
  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus();

  adder_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // The external ripple Adder living beside the arbiter.
  assign {bus.add_co, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{W{1'b0}}, bus.add_ci};

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           cout;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] rq, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (rq[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.a_in[i*W +: W] = a;
    bus.b_in[i*W +: W] = b;
    bus.c_in[i]        = c;
  endtask

  // Starts at a negedge in IDLE with bus.req already set; ends at the
  // negedge after the HOLD->IDLE edge.
  task automatic txn(input int hold, input bit rearm, input logic [NREQ-1:0] extra);
    int w;
    logic [W-1:0] a, b;
    logic c;
    logic [W:0] s;
    logic [NREQ-1:0] oh;
    exp_t e, got;
    w = pick(bus.req, m_ptr);
    if (w < 0) begin
      checks++; failures++;
      $error("FAIL txn_setup observed=none expected=request");
      return;
    end
    a = bus.a_in[w*W +: W];
    b = bus.b_in[w*W +: W];
    c = bus.c_in[w];
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.id = IDW'(w); e.sum = s[W-1:0]; e.cout = s[W];
    sb.push_back(e);

    @(negedge clk);  // ISSUE
    oh = '0; oh[w] = 1'b1;
    chk("gnt", 32'(bus.gnt), 32'(oh));
    chk("add_a", 32'(bus.add_a), 32'(a));
    chk("add_b", 32'(bus.add_b), 32'(b));
    chk("add_ci", 32'(bus.add_ci), 32'(c));
    chk("busy_issue", 32'(bus.busy), 32'd1);
    chk("valid_issue", 32'(bus.res_valid), 32'd0);
    bus.req[w] = 1'b0;

    @(negedge clk);  // HOLD
    chk("gnt_pulse", 32'(bus.gnt), 32'd0);
    chk("res_valid", 32'(bus.res_valid), 32'd1);
    if (sb.size() == 0) begin
      checks++; failures++;
      $error("FAIL sb_empty observed=result expected=none");
      got = '0;
    end else begin
      got = sb.pop_front();
    end
    chk("res_id", 32'(bus.res_id), 32'(got.id));
    chk("res_sum", 32'(bus.res_sum), 32'(got.sum));
    chk("res_cout", 32'(bus.res_cout), 32'(got.cout));
    if (rearm) bus.req[w] = 1'b1;
    bus.req = bus.req | extra;

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.res_valid), 32'd1);
      chk("bp_sum", 32'(bus.res_sum), 32'(got.sum));
      chk("bp_id", 32'(bus.res_id), 32'(got.id));
      chk("bp_gnt", 32'(bus.gnt), 32'd0);
      chk("bp_add_a", 32'(bus.add_a), 32'(a));
    end

    bus.res_ready = 1'b1;
    @(negedge clk);  // back in IDLE
    bus.res_ready = 1'b0;
    chk("valid_drop", 32'(bus.res_valid), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    m_ptr = (w + 1) % NREQ;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held_a;
    rst = 1'b1;
    bus.req = '0; bus.a_in = '0; bus.b_in = '0; bus.c_in = '0; bus.res_ready = 1'b0;
    set_ops(0, 4'd9,  4'd8,  1'b1);
    set_ops(1, 4'd3,  4'd4,  1'b0);
    set_ops(2, 4'd7,  4'd7,  1'b1);
    set_ops(3, 4'd15, 4'd15, 1'b1);

    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_add_a", 32'(bus.add_a), 32'd0);
    chk("rst_add_b", 32'(bus.add_b), 32'd0);
    chk("rst_add_ci", 32'(bus.add_ci), 32'd0);
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_id", 32'(bus.res_id), 32'd0);
    chk("rst_sum", 32'(bus.res_sum), 32'd0);
    chk("rst_cout", 32'(bus.res_cout), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;

    // No requests: nothing moves.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_gnt", 32'(bus.gnt), 32'd0);
      chk("idle_valid", 32'(bus.res_valid), 32'd0);
      chk("idle_add_a", 32'(bus.add_a), 32'd0);
    end

    // Single op from requester 0 (9+8+1 = 18 -> sum 2, cout 1), then 5 cycles
    // of backpressure while requesters 1 and 3 raise req.
    bus.req = 4'b0001;
    txn(5, 1'b0, 4'b1010);
    txn(0, 1'b0, 4'b0000);  // id 1
    txn(0, 1'b0, 4'b0000);  // id 3

    // Round robin with everybody re-requesting: 0,1,2,3,0.
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) txn(0, 1'b1, 4'b0000);
    bus.req = 4'b0000;

    // Move the pointer to 3, then wrap 3 -> 0.
    bus.req = 4'b0100;
    txn(0, 1'b0, 4'b0000);
    bus.req = 4'b1001;
    txn(0, 1'b0, 4'b0000);  // id 3, 15+15+1
    txn(0, 1'b0, 4'b0000);  // id 0 after wrap

    // Asynchronous reset while a result sits in HOLD.
    bus.req = 4'b0100;
    @(negedge clk);
    chk("pre_rst_gnt", 32'(bus.gnt), 32'b0100);
    bus.req = 4'b0000;
    held_a = bus.add_a;
    chk("pre_rst_add_a", 32'(held_a), 32'd7);
    @(negedge clk);
    chk("pre_rst_valid", 32'(bus.res_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.res_valid), 32'd0);
    chk("arst_sum", 32'(bus.res_sum), 32'd0);
    chk("arst_id", 32'(bus.res_id), 32'd0);
    chk("arst_add_a", 32'(bus.add_a), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_gnt", 32'(bus.gnt), 32'd0);
      chk("post_rst_valid", 32'(bus.res_valid), 32'd0);
    end
    // Pointer is back at 0, so requester 0 wins over 1.
    bus.req = 4'b0011;
    txn(0, 1'b0, 4'b0000);
    txn(0, 1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
